// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding, load-use bubbles and flush.
// One-cycle latency; in_ready drops on downstream stall or load-use hazard, rises on flush.
module id_ex_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int OPC_W     = 6,
  parameter int LOAD_OPC  = 13,
  parameter int STORE_OPC = 14,
  parameter int BEQ_OPC   = 15,
  parameter int BLT_OPC   = 19,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [REG_AW-1:0] in_rs_addr,
  input  logic [REG_AW-1:0] in_rt_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              exm_valid,
  input  logic              exm_reg_write,
  input  logic              exm_is_load,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OPC_W-1:0]  ex_opcode,
  output logic [DATA_W-1:0] ex_operand1,
  output logic [DATA_W-1:0] ex_operand2,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic              ex_is_branch,
  output logic [CNT_W-1:0]  stall_count
);

  logic              r_valid;
  logic [OPC_W-1:0]  r_opcode;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [DATA_W-1:0] r_store;
  logic [REG_AW-1:0] r_rd;
  logic              r_reg_write;
  logic              r_is_load;
  logic              r_is_branch;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_rt_used;
  logic              w_hazard;
  logic              w_slot_free;
  logic              w_accept;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // A load in exm has no result yet, so it is never a forwarding source.
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] addr,
                                            input logic [DATA_W-1:0] rf);
    if (addr == '0)
      fwd = '0;
    else if (exm_valid && exm_reg_write && !exm_is_load && exm_rd_addr == addr)
      fwd = exm_result;
    else if (wb_valid && wb_reg_write && wb_rd_addr == addr)
      fwd = wb_data;
    else
      fwd = rf;
  endfunction

  assign w_rt_used   = !in_use_imm || (in_opcode == OPC_W'(STORE_OPC));
  assign w_hazard    = in_valid && exm_valid && exm_is_load && exm_reg_write &&
                       (exm_rd_addr != '0) &&
                       ((exm_rd_addr == in_rs_addr) || (w_rt_used && exm_rd_addr == in_rt_addr));
  assign w_slot_free = !r_valid || ex_ready;
  assign in_ready    = flush || (w_slot_free && !w_hazard);
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_fwd_rs    = fwd(in_rs_addr, in_rs_data);
  assign w_fwd_rt    = fwd(in_rt_addr, in_rt_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_opcode    <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_store     <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_is_load   <= 1'b0;
      r_is_branch <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid     <= 1'b1;
        r_opcode    <= in_opcode;
        r_op1       <= w_fwd_rs;
        r_op2       <= in_use_imm ? in_imm : w_fwd_rt;
        r_store     <= w_fwd_rt;
        r_rd        <= in_rd_addr;
        r_reg_write <= in_reg_write;
        r_is_load   <= (in_opcode == OPC_W'(LOAD_OPC));
        r_is_branch <= (in_opcode == OPC_W'(BEQ_OPC)) || (in_opcode == OPC_W'(BLT_OPC));
      end else if (w_slot_free) begin
        r_valid <= 1'b0;
      end
      if (w_hazard && !flush && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_opcode     = r_opcode;
  assign ex_operand1   = r_op1;
  assign ex_operand2   = r_op2;
  assign ex_store_data = r_store;
  assign ex_rd_addr    = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_is_load    = r_is_load;
  assign ex_is_branch  = r_is_branch;
  assign stall_count   = r_stall_cnt;

endmodule
